// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multicycle RISC-V control FSM (IF/ID/EX/MEM/WB) with mem_ack timeout.
// Define CTRL_ILLEGAL_TRAP_EN to halt on unsupported opcodes; otherwise they run as NOPs.
module ctrl_fsm #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        mem_ack,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [3:0]  ALUCtrl,
  output logic        loadPC,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        mem_err,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        zero_q, zero_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ldok_q, ldok_d;
  logic        illegal_q, illegal_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       is_r, is_i, is_ld, is_st, is_br;
  logic       ex_phase, timeout;
  logic [3:0] alu_code;
  logic       unused_ir;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign f7b5      = ir_q[30];
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  assign is_r  = (opcode == 7'b0110011);
  assign is_i  = (opcode == 7'b0010011);
  assign is_ld = (opcode == 7'b0000011);
  assign is_st = (opcode == 7'b0100011);
  assign is_br = (opcode == 7'b1100011);

  assign timeout = (state_q == S_MEM) && !mem_ack && (cnt_q == CNT_LAST);

  always_comb begin
    alu_code = 4'b0010;
    if (is_br) begin
      alu_code = 4'b0110;
    end else if (is_r || is_i) begin
      case (funct3)
        3'b000:  alu_code = (is_r && f7b5) ? 4'b0110 : 4'b0010;
        3'b111:  alu_code = 4'b0000;
        3'b110:  alu_code = 4'b0001;
        3'b100:  alu_code = 4'b1101;
        3'b010:  alu_code = 4'b0111;
        3'b001:  alu_code = 4'b1001;
        3'b101:  alu_code = f7b5 ? 4'b1010 : 4'b1000;
        default: alu_code = 4'b0010;
      endcase
    end else if (!(is_ld || is_st)) begin
      alu_code = 4'b0000;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    zero_d    = zero_q;
    cnt_d     = cnt_q;
    ldok_d    = ldok_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IF: begin
        ir_d    = instr;
        state_d = S_ID;
      end
      S_ID: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (!(is_r || is_i || is_ld || is_st || is_br)) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EX;
        end
`else
        state_d = S_EX;
`endif
      end
      S_EX: begin
        zero_d  = Zero;
        cnt_d   = 8'd0;
        ldok_d  = 1'b0;
        state_d = (is_ld || is_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        // An ack in the timeout cycle still counts as a completed access.
        if (mem_ack) begin
          ldok_d  = 1'b1;
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IF;
      ir_q      <= 32'd0;
      zero_q    <= 1'b0;
      cnt_q     <= 8'd0;
      ldok_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      zero_q    <= zero_d;
      cnt_q     <= cnt_d;
      ldok_q    <= ldok_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_phase = (state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB);

  always_comb begin
    ALUCtrl  = ex_phase ? alu_code : 4'b0000;
    ALUSrc   = ex_phase && (is_i || is_ld || is_st);
    MemRead  = (state_q == S_MEM) && is_ld;
    MemWrite = (state_q == S_MEM) && is_st;
    MemToReg = is_ld && ((state_q == S_MEM) || (state_q == S_WB));
    RegWrite = (state_q == S_WB) && (is_r || is_i || (is_ld && ldok_q));
    loadPC   = (state_q == S_WB);
    PCSrc    = (state_q == S_WB) && is_br && zero_q;
    mem_err  = timeout;
    illegal  = illegal_q;
    state    = state_q;
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - scoreboard bench for ctrl_fsm: per-cycle expected outputs from a phase-level model.
module tb_ctrl_fsm;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        Zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, mem_err, illegal;
  logic [3:0]  ALUCtrl;
  logic [2:0]  state;

  ctrl_fsm #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ack(mem_ack),
    .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .ALUCtrl(ALUCtrl), .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_err(mem_err), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef logic [15:0] obs_t;
  typedef enum int {T_R, T_I, T_LD, T_ST, T_BR, T_ILL} ityp_e;

  obs_t act;
  assign act = {state, ALUCtrl, PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, mem_err, illegal};

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got {st,alu,pcs,asrc,rw,m2r,lpc,mr,mw,merr,ill}=%b want %b at %0t", name, got, want, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL underflow: got %b want (nothing queued)", act);
        end else begin
          check("cycle", act, exp_q.pop_front());
        end
      end
    end
  end

  function automatic ityp_e classify(input logic [31:0] i);
    case (i[6:0])
      7'b0110011: return T_R;
      7'b0010011: return T_I;
      7'b0000011: return T_LD;
      7'b0100011: return T_ST;
      7'b1100011: return T_BR;
      default:    return T_ILL;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [31:0] i);
    ityp_e t = classify(i);
    if (t == T_LD || t == T_ST) return 4'b0010;
    if (t == T_BR) return 4'b0110;
    if (t == T_ILL) return 4'b0000;
    case (i[14:12])
      3'b000:  return (t == T_R && i[30]) ? 4'b0110 : 4'b0010;
      3'b111:  return 4'b0000;
      3'b110:  return 4'b0001;
      3'b100:  return 4'b1101;
      3'b010:  return 4'b0111;
      3'b001:  return 4'b1001;
      3'b101:  return i[30] ? 4'b1010 : 4'b1000;
      default: return 4'b0010;
    endcase
  endfunction

  // ph: 0=IF 1=ID 2=EX 3=MEM 4=WB
  function automatic obs_t expect_obs(input int ph, input logic [31:0] i, input bit z,
                                      input bit acked, input bit tout);
    ityp_e t = classify(i);
    bit ex = (ph >= 2 && ph <= 4);
    bit wb = (ph == 4);
    bit mem = (ph == 3);
    logic [2:0] st = 3'(ph);
    logic [3:0] alu = ex ? alu_of(i) : 4'b0000;
    bit asrc = ex && (t == T_I || t == T_LD || t == T_ST);
    bit pcs  = wb && (t == T_BR) && z;
    bit rw   = wb && (t == T_R || t == T_I || (t == T_LD && acked));
    bit m2r  = (t == T_LD) && (mem || wb);
    bit mr   = mem && (t == T_LD);
    bit mw   = mem && (t == T_ST);
    return {st, alu, pcs, asrc, rw, m2r, wb, mr, mw, tout, 1'b0};
  endfunction

  task automatic step(input logic [31:0] i, input bit z, input bit a, input obs_t e);
    instr   = i;
    Zero    = z;
    mem_ack = a;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ack_at: MEM cycle index carrying the ack, or -1 for no ack (timeout).
  task automatic run_instr(input logic [31:0] i, input int ack_at, input bit zex);
    ityp_e t = classify(i);
    bit acked = (ack_at >= 0);
    int nmem = acked ? ack_at + 1 : TO;
    step(i, rbit(), rbit(), expect_obs(0, i, zex, acked, 1'b0));
    step($urandom, rbit(), rbit(), expect_obs(1, i, zex, acked, 1'b0));
    step($urandom, zex, rbit(), expect_obs(2, i, zex, acked, 1'b0));
    if (t == T_LD || t == T_ST) begin
      for (int k = 0; k < nmem; k++) begin
        step($urandom, rbit(), (k == ack_at), expect_obs(3, i, zex, acked, !acked && k == TO - 1));
      end
    end
    step($urandom, rbit(), rbit(), expect_obs(4, i, zex, acked, 1'b0));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i = $urandom;
    logic [6:0]  ops[5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
`ifdef CTRL_ILLEGAL_TRAP_EN
    int sel = $urandom_range(0, 4);
`else
    int sel = $urandom_range(0, 5);
`endif
    if (sel < 5) begin
      i[6:0] = ops[sel];
    end else begin
      do i[6:0] = 7'($urandom_range(0, 127)); while (classify(i) != T_ILL);
    end
    if ((classify(i) == T_R || classify(i) == T_I) && i[14:12] == 3'b011) i[14:12] = 3'b000;
    return i;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] lw;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", act, 16'd0);
    rst    = 1'b1;
    mon_en = 1'b1;

    run_instr(32'h002081B3, -1, 1'b0);
    run_instr(32'h0000A183, 3, 1'b0);
    run_instr(32'h0030A023, -1, 1'b0);
    run_instr(32'h00208463, -1, 1'b1);
    run_instr(32'h00208463, -1, 1'b0);
    run_instr(32'h0000A183, TO - 1, 1'b0);
    run_instr(32'h0000A183, -1, 1'b1);
    run_instr(32'h0000A183, 0, 1'b1);
`ifndef CTRL_ILLEGAL_TRAP_EN
    run_instr(32'h00000000, -1, 1'b1);
`endif
    for (int n = 0; n < 150; n++) begin
      logic [31:0] ri = rand_instr();
      int ack_at = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      run_instr(ri, ack_at, rbit());
    end

    lw = 32'h0000A183;
    step(lw, 1'b0, 1'b0, expect_obs(0, lw, 1'b0, 1'b0, 1'b0));
    step(lw, 1'b0, 1'b0, expect_obs(1, lw, 1'b0, 1'b0, 1'b0));
    step(lw, 1'b0, 1'b0, expect_obs(2, lw, 1'b0, 1'b0, 1'b0));
    step(lw, 1'b0, 1'b0, expect_obs(3, lw, 1'b0, 1'b0, 1'b0));
    mon_en  = 1'b0;
    mem_ack = 1'b0;
    #1;
    check("mid_mem_read", act, expect_obs(3, lw, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    #1;
    check("async_reset", act, 16'd0);
    @(posedge clk);
    #1;
    check("reset_hold", act, 16'd0);
    rst    = 1'b1;
    mon_en = 1'b1;
    run_instr(32'h002081B3, -1, 1'b1);
    run_instr(32'h0000A183, 1, 1'b0);

`ifdef CTRL_ILLEGAL_TRAP_EN
    step(32'h0, 1'b0, 1'b0, expect_obs(0, 32'h0, 1'b0, 1'b0, 1'b0));
    step($urandom, 1'b0, 1'b1, expect_obs(1, 32'h0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 20; k++) begin
      step($urandom, rbit(), rbit(), {3'd5, 12'd0, 1'b1});
    end
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("halt_reset", act, 16'd0);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;
    run_instr(32'h002081B3, -1, 1'b0);
`endif

    mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d queued want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
# ctrl_fsm

Multicycle control unit that drives the RISC-V datapath's control inputs and the data-memory strobes. It consumes the fetched instruction and the ALU `Zero` flag, and sequences each instruction through IF/ID/EX/MEM/WB. It issues exactly one `loadPC` pulse per retired instruction. It waits on a data-memory acknowledge, with a bounded timeout.

## Interface
- `ACK_TIMEOUT`, default 15: maximum MEM-state cycles without `mem_ack` before the access is abandoned (range 1–255).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low (asserted when 0).
- `instr`  in  32  fetched instruction, valid during IF.
- `Zero`  in  1  ALU zero flag from the datapath.
- `mem_ack`  in  1  data memory completed the access this cycle.
- `PCSrc`  out  1  PC takes branch target.
- `ALUSrc`  out  1  ALU op2 = immediate.
- `RegWrite`  out  1  register-file write enable.
- `MemToReg`  out  1  write-back selects `dReadData`.
- `ALUCtrl`  out  4  ALU operation.
- `loadPC`  out  1  PC update strobe.
- `MemRead`  out  1  data-memory read request.
- `MemWrite`  out  1  data-memory write request.
- `mem_err`  out  1  one-cycle pulse on an ack timeout.
- `illegal`  out  1  sticky unsupported-opcode flag.
- `state`  out  3  current state, for debug.

## Operation
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
- Transitions: IF→ID→EX.
  - EX→MEM for load (0000011) and store (0100011).
  - EX→WB for all other opcodes.
  - MEM→WB on `mem_ack` or on timeout.
  - WB→IF.
  - HALT is absorbing until reset.
- `instr` is latched into an internal IR on the IF→ID edge. All decode uses the IR.
- Supported opcodes:
  - R: 0110011
  - I-ALU: 0010011
  - load: 0000011
  - store: 0100011
  - BEQ: 1100011, any funct3 treated as BEQ
- ALUCtrl codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
- R/I decode by funct3:
  - 000 → ADD; SUB only for R with funct7[5]=1
  - 111 → AND, 110 → OR, 100 → XOR, 010 → SLT, 001 → SLL
  - 101 → SRL, or SRA when funct7[5]=1
- Load and store use ADD. Branch uses SUB.
- Outputs are Moore-decoded from the state and the IR.
  - `ALUCtrl`/`ALUSrc` are valid from EX through WB and are 0 elsewhere.
  - `ALUSrc`=1 for I-ALU, load and store.
  - `MemRead` (load) or `MemWrite` (store) is high during the whole MEM state.
  - `MemToReg`=1 in MEM and WB for a load.
  - `RegWrite`=1 only in WB, for R, I-ALU, and a load that completed with an ack.
  - `loadPC`=1 only in WB, every instruction.
  - `PCSrc`=BEQ & `zero_q` in WB, where `zero_q` is `Zero` registered at the end of EX.
- Timeout: an 8-bit counter clears on MEM entry and increments each MEM cycle without an ack.
  - At count == `ACK_TIMEOUT`-1 with no ack, the FSM goes to WB, `mem_err` pulses that cycle, and a load does not write back.
  - If `mem_ack` arrives in the same cycle as the timeout, the ack wins.

## Timing
- Reset (`rst`=0): state=IF, IR=0, `zero_q`=0, counter=0, `illegal`=0. All outputs go to 0 immediately, including `MemRead`/`MemWrite` in the middle of an access.
- Latency: R/I/branch take 4 cycles. Load/store take 5 cycles with a same-cycle ack, plus 1 cycle per wait cycle.
- `mem_ack` is sampled only in MEM and ignored in other states.
- `MemRead`/`MemWrite` fall on the WB entry edge.
- Exactly one `loadPC` pulse per instruction. `RegWrite` and `loadPC` are coincident in WB.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: an unsupported opcode in ID moves the FSM to HALT. `illegal` is set sticky and no further `loadPC` is issued.
- `CTRL_ILLEGAL_TRAP_EN` undefined: an unsupported opcode executes as a NOP (ID→EX→WB, `loadPC`=1, `RegWrite`=0, `PCSrc`=0). `illegal` is tied 0.

## Test plan
- Reset, then `instr`=0x002081B3 (add): `state` goes 0,1,2,4. In EX–WB, `ALUCtrl`=0010 and `ALUSrc`=0. In WB, `RegWrite`=`loadPC`=1 and `PCSrc`=0.
- `instr`=0x0000A183 (lw) with `mem_ack` on the 4th MEM cycle: `MemRead` is high for 4 cycles. In WB, `MemToReg`=1, `RegWrite`=1, `ALUCtrl`=0010.
- `instr`=0x0030A023 (sw) with `mem_ack` held 0 and `ACK_TIMEOUT`=15: `MemWrite` is high for 15 cycles, `mem_err` pulses once, and WB has `RegWrite`=0 and `loadPC`=1.
- `instr`=0x00208463 (beq) with `Zero`=1 in EX: WB has `PCSrc`=1 and `loadPC`=1. Repeat with `Zero`=0: `PCSrc`=0.
- `instr`=0x00000000:
  - With the macro: `state`=5 and `illegal`=1, held for 20 cycles with no `loadPC`.
  - Without the macro: 4-cycle NOP with `RegWrite`=0.
- `rst` driven to 0 in the 2nd MEM wait cycle of a lw: `MemRead`=0 in the same cycle, and after release `state`=0 with no `RegWrite`.
